// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register and the execute stage: operands in, stall back,
// and the registered EX/MEM results out.
interface ex_stage_if #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 20,
    parameter int OP_W    = 4
);
    logic               in_valid;
    logic [OP_W-1:0]    opcode;
    logic [INSTR_W-1:0] instruction;
    logic [DATA_W-1:0]  operand_a;
    logic [DATA_W-1:0]  operand_b;
    logic               stall;
    logic [DATA_W-1:0]  ex_result;
    logic [3:0]         ex_rd;
    logic               ex_wr_en;
    logic [OP_W-1:0]    ex_opcode;
    logic               ex_valid;

    modport master (
        output in_valid, opcode, instruction, operand_a, operand_b,
        input  stall, ex_result, ex_rd, ex_wr_en, ex_opcode, ex_valid
    );

    modport slave (
        input  in_valid, opcode, instruction, operand_a, operand_b,
        output stall, ex_result, ex_rd, ex_wr_en, ex_opcode, ex_valid
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a DATA_W-cycle shift-add multiplier that
// stalls upstream until its last iteration.
module ex_stage #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 20,
    parameter int OP_W    = 4
) (
    input logic        clock,
    input logic        reset,
    ex_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int RD_LSB = INSTR_W - 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  a_shift_q, a_shift_d;
    logic [DATA_W-1:0]  b_shift_q, b_shift_d;
    logic [3:0]         mul_rd_q, mul_rd_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [3:0]         rd_q, rd_d;
    logic               wr_en_q, wr_en_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic               valid_q, valid_d;
    logic               stall;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  acc_step;
    logic [7:0]         imm8;
    logic [3:0]         instr_rd;
    logic               unused_instr_bits;

    assign imm8     = bus.instruction[7:0];
    assign instr_rd = bus.instruction[RD_LSB+3:RD_LSB];
    assign unused_instr_bits = ^{bus.instruction[INSTR_W-1:RD_LSB+4], bus.instruction[RD_LSB-1:8]};

    always_comb begin
        alu_out = '0;
        case (bus.opcode)
            OP_ADD:  alu_out = bus.operand_a + bus.operand_b;
            OP_SUB:  alu_out = bus.operand_a - bus.operand_b;
            OP_AND:  alu_out = bus.operand_a & bus.operand_b;
            OP_OR:   alu_out = bus.operand_a | bus.operand_b;
            OP_SLT:  alu_out = ($signed(bus.operand_a) < $signed(bus.operand_b)) ? DATA_W'(1) : '0;
            OP_ADDI: alu_out = bus.operand_a + {{(DATA_W-8){imm8[7]}}, imm8};
            OP_SLL:  alu_out = bus.operand_a << bus.operand_b[CNT_W-1:0];
            default: alu_out = '0;
        endcase
    end

    // Stall drops in the final multiply iteration so upstream advances on the completing edge.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        a_shift_d = a_shift_q;
        b_shift_d = b_shift_q;
        mul_rd_d  = mul_rd_q;
        result_d  = result_q;
        rd_d      = rd_q;
        opcode_d  = opcode_q;
        wr_en_d   = 1'b0;
        valid_d   = 1'b0;
        stall     = 1'b0;
        acc_step  = b_shift_q[0] ? acc_q + a_shift_q : acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.opcode == OP_MUL) begin
                        stall     = 1'b1;
                        a_shift_d = bus.operand_a;
                        b_shift_d = bus.operand_b;
                        mul_rd_d  = instr_rd;
                        count_d   = '0;
                        acc_d     = '0;
                        state_d   = MUL;
                    end else begin
                        result_d = alu_out;
                        rd_d     = instr_rd;
                        opcode_d = bus.opcode;
                        wr_en_d  = (bus.opcode >= OP_ADD) && (bus.opcode <= OP_SLL);
                        valid_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                stall     = (count_q != CNT_LAST);
                acc_d     = acc_step;
                a_shift_d = a_shift_q << 1;
                b_shift_d = b_shift_q >> 1;
                count_d   = count_q + 1'b1;
                if (count_q == CNT_LAST) begin
                    result_d = acc_step;
                    rd_d     = mul_rd_q;
                    opcode_d = OP_MUL;
                    wr_en_d  = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            a_shift_q <= '0;
            b_shift_q <= '0;
            mul_rd_q  <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            wr_en_q   <= 1'b0;
            opcode_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            a_shift_q <= a_shift_d;
            b_shift_q <= b_shift_d;
            mul_rd_q  <= mul_rd_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            wr_en_q   <= wr_en_d;
            opcode_q  <= opcode_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.ex_result = result_q;
    assign bus.ex_rd     = rd_q;
    assign bus.ex_wr_en  = wr_en_q;
    assign bus.ex_opcode = opcode_q;
    assign bus.ex_valid  = valid_q;
endmodule
